// File: rtl/dpram_be.sv
// dpram_be: parametrised true dual-port synchronous RAM with byte-lane write
// enables, selectable read-during-write behaviour, an optional output
// register stage, deterministic cross-port collision resolution and a
// post-reset zero-fill sequencer.
//
// Ports:
//   clk, rst                 clock (rising edge) and synchronous active-high reset
//   a_en/a_we/a_be/a_addr/a_wdata   port A request (pipeline MEM stage)
//   a_rdata/a_rvalid         port A returned data and one-cycle valid pulse
//   b_*                      same as port A, for the debug/DMA master
//   busy                     clear sequence running; all requests are ignored
//   collision                one-cycle pulse: both ports wrote the same word
//                            with at least one overlapping byte lane
module dpram_be #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned RDW_MODE     = 0,
    parameter int unsigned OUT_REG      = 0,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_en,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    input  logic                b_en,
    input  logic                b_we,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rvalid,
    output logic                busy,
    output logic                collision
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("dpram_be: DATA_W must be a multiple of 8");
    end

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                clear_wr;
    logic                a_acc, b_acc, a_wr, b_wr;
    logic [DATA_W-1:0]   a_old, b_old, a_merged, b_merged, a_ret, b_ret;
    logic                collision_d, collision_q;

    logic                a_rv1_d, a_rv1_q, b_rv1_d, b_rv1_q;
    logic [DATA_W-1:0]   a_rd1_d, a_rd1_q, b_rd1_d, b_rd1_q;
    logic                a_rv2_d, a_rv2_q, b_rv2_d, b_rv2_q;
    logic [DATA_W-1:0]   a_rd2_d, a_rd2_q, b_rd2_d, b_rd2_q;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (CLEAR_ON_RST == 0) begin
            state_d   = ST_READY;
            clr_cnt_d = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == '1) begin
                        state_d = ST_READY;
                    end
                end
                default: begin
                    state_d = ST_READY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clear_wr = busy && !rst;

    // ------------------------------------------------------------------
    // Request acceptance and returned-data selection
    // ------------------------------------------------------------------
    assign a_acc = a_en && !busy && !rst;
    assign b_acc = b_en && !busy && !rst;
    assign a_wr  = a_acc && a_we;
    assign b_wr  = b_acc && b_we;

    assign a_old = mem_q[a_addr];
    assign b_old = mem_q[b_addr];

    // Each port's merged word uses only its own write, so the returned data
    // never reflects the other port's same-cycle write.
    always_comb begin
        a_merged = a_old;
        b_merged = b_old;
        for (int unsigned i = 0; i < NB; i++) begin
            if (a_be[i]) a_merged[8*i +: 8] = a_wdata[8*i +: 8];
            if (b_be[i]) b_merged[8*i +: 8] = b_wdata[8*i +: 8];
        end
    end

    assign a_ret = (a_wr && RDW_MODE == 0) ? a_merged : a_old;
    assign b_ret = (b_wr && RDW_MODE == 0) ? b_merged : b_old;

    assign collision_d = a_wr && b_wr && (a_addr == b_addr) && |(a_be & b_be);

    // ------------------------------------------------------------------
    // Array write: clear has exclusive use while busy. Port B lanes are
    // assigned before port A lanes so that A wins on overlapping lanes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear_wr) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (b_wr && b_be[i]) mem_q[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
                if (a_wr && a_be[i]) mem_q[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline: stage 1 always exists, stage 2 is selected by OUT_REG.
    // Data registers hold when no access completes.
    // ------------------------------------------------------------------
    always_comb begin
        a_rv1_d = a_acc;
        b_rv1_d = b_acc;
        a_rd1_d = a_acc ? a_ret : a_rd1_q;
        b_rd1_d = b_acc ? b_ret : b_rd1_q;
        a_rv2_d = a_rv1_q;
        b_rv2_d = b_rv1_q;
        a_rd2_d = a_rv1_q ? a_rd1_q : a_rd2_q;
        b_rd2_d = b_rv1_q ? b_rd1_q : b_rd2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rv1_q     <= 1'b0;
            b_rv1_q     <= 1'b0;
            a_rd1_q     <= '0;
            b_rd1_q     <= '0;
            a_rv2_q     <= 1'b0;
            b_rv2_q     <= 1'b0;
            a_rd2_q     <= '0;
            b_rd2_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            a_rv1_q     <= a_rv1_d;
            b_rv1_q     <= b_rv1_d;
            a_rd1_q     <= a_rd1_d;
            b_rd1_q     <= b_rd1_d;
            a_rv2_q     <= a_rv2_d;
            b_rv2_q     <= b_rv2_d;
            a_rd2_q     <= a_rd2_d;
            b_rd2_q     <= b_rd2_d;
            collision_q <= collision_d;
        end
    end

    assign a_rdata   = (OUT_REG != 0) ? a_rd2_q : a_rd1_q;
    assign a_rvalid  = (OUT_REG != 0) ? a_rv2_q : a_rv1_q;
    assign b_rdata   = (OUT_REG != 0) ? b_rd2_q : b_rd1_q;
    assign b_rvalid  = (OUT_REG != 0) ? b_rv2_q : b_rv1_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be: three dpram_be instances (write-first, read-first, and
// write-first with output register) share one stimulus stream. A reference
// memory model produces expected returned words, which are queued per port
// when stimulus is driven and popped when the DUT asserts rvalid.
module tb_dpram_be;

    logic        clk;
    logic        rst;
    logic        a_en, a_we, b_en, b_we;
    logic [3:0]  a_be, b_be;
    logic [3:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    // port index: 0/1 = dut0 A/B, 2/3 = dut1 A/B, 4/5 = dut2 A/B
    logic [31:0] rd [6];
    logic        rv [6];
    logic        bsy [3];
    logic        col [3];

    logic [31:0] sb [6][$];
    logic [31:0] mdl [16];
    logic        mdl_ready;

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dpram_be #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) dut0 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(rd[0]), .a_rvalid(rv[0]),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(rd[1]), .b_rvalid(rv[1]),
        .busy(bsy[0]), .collision(col[0]));

    dpram_be #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RST(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(rd[2]), .a_rvalid(rv[2]),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(rd[3]), .b_rvalid(rv[3]),
        .busy(bsy[1]), .collision(col[1]));

    dpram_be #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(1), .CLEAR_ON_RST(1)) dut2 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(rd[4]), .a_rvalid(rv[4]),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(rd[5]), .b_rvalid(rv[5]),
        .busy(bsy[2]), .collision(col[2]));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // Scoreboard consumer: every rvalid pulse must match the oldest queued word.
    always @(negedge clk) begin
        for (int p = 0; p < 6; p++) begin
            if (rv[p] === 1'b1) begin
                vectors++;
                if (sb[p].size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rvalid port %0d: got data %h, required no rvalid", p, rd[p]);
                end else begin
                    logic [31:0] exp;
                    exp = sb[p].pop_front();
                    if (rd[p] !== exp) begin
                        miscompares++;
                        $display("FAIL rdata port %0d: got %h, required %h", p, rd[p], exp);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        a_en = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
        b_en = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
    endtask

    // One clock of stimulus on both ports; queues expected returns and
    // updates the reference model (B lanes first, then A overrides).
    task automatic drive(input logic ae, input logic awe, input logic [3:0] abe,
                         input logic [3:0] aad, input logic [31:0] awd,
                         input logic b_e, input logic bwe, input logic [3:0] bbe,
                         input logic [3:0] bad, input logic [31:0] bwd);
        logic [31:0] oa, ob;
        @(negedge clk); #1;
        a_en = ae; a_we = awe; a_be = abe; a_addr = aad; a_wdata = awd;
        b_en = b_e; b_we = bwe; b_be = bbe; b_addr = bad; b_wdata = bwd;
        if (mdl_ready) begin
            oa = mdl[aad];
            ob = mdl[bad];
            if (ae) begin
                sb[0].push_back(awe ? merge(oa, awd, abe) : oa);
                sb[2].push_back(oa);
                sb[4].push_back(awe ? merge(oa, awd, abe) : oa);
            end
            if (b_e) begin
                sb[1].push_back(bwe ? merge(ob, bwd, bbe) : ob);
                sb[3].push_back(ob);
                sb[5].push_back(bwe ? merge(ob, bwd, bbe) : ob);
            end
            if (b_e && bwe) mdl[bad] = merge(mdl[bad], bwd, bbe);
            if (ae && awe)  mdl[aad] = merge(mdl[aad], awd, abe);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        mdl_ready = 0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) begin
                for (int p = 0; p < 6; p++) begin
                    vectors++;
                    if (rd[p] !== 32'h0 || rv[p] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL reset_outputs port %0d: got rdata %h rvalid %b, required 0 0", p, rd[p], rv[p]);
                    end
                end
                for (int d = 0; d < 3; d++) begin
                    vectors++;
                    if (col[d] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL reset_collision dut %0d: got %b, required 0", d, col[d]);
                    end
                end
            end
            for (int d = 0; d < 3; d++) begin
                vectors++;
                if (bsy[d] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL clear_busy dut %0d cycle %0d: got %b, required 1", d, i, bsy[d]);
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (bsy[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL clear_done dut %0d: got busy %b, required 0", d, bsy[d]);
            end
        end
        mdl_ready = 1;
    endtask

    task automatic test_clear_readback();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 4'h0, 4'(i), 32'h0, 1, 0, 4'h0, 4'(15 - i), 32'h0);
        end
        idle(3);
    endtask

    task automatic test_byte_enable();
        drive(1, 1, 4'hF, 4'd3, 32'hAABBCCDD, 0, 0, 4'h0, 4'd0, 32'h0);
        drive(1, 1, 4'h5, 4'd3, 32'h11223344, 0, 0, 4'h0, 4'd0, 32'h0);
        drive(1, 0, 4'h0, 4'd3, 32'h0, 1, 0, 4'h0, 4'd3, 32'h0);
        @(negedge clk);
        vectors++;
        if (rd[0] !== 32'hAA22CC44 || rv[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL byte_enable: got %h valid %b, required aa22cc44 valid 1", rd[0], rv[0]);
        end
        idle(3);
    endtask

    task automatic test_rdw();
        drive(1, 1, 4'hF, 4'd7, 32'h12345678, 0, 0, 4'h0, 4'd0, 32'h0);
        drive(1, 1, 4'hF, 4'd7, 32'hFFFFFFFF, 0, 0, 4'h0, 4'd0, 32'h0);
        @(negedge clk);
        vectors++;
        if (rd[0] !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL rdw_write_first: got %h, required ffffffff", rd[0]);
        end
        vectors++;
        if (rd[2] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL rdw_read_first: got %h, required 12345678", rd[2]);
        end
        // partial-lane write through port B: write-first returns the merged word
        drive(0, 0, 4'h0, 4'd0, 32'h0, 1, 1, 4'h8, 4'd7, 32'hA5A5A5A5);
        @(negedge clk);
        vectors++;
        if (rd[1] !== 32'hA5FFFFFF || rd[3] !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL rdw_partial: got wf %h rf %h, required a5ffffff ffffffff", rd[1], rd[3]);
        end
        idle(3);
    endtask

    task automatic test_collision();
        drive(1, 1, 4'h3, 4'd9, 32'h11111111, 1, 1, 4'h6, 4'd9, 32'h22222222);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (col[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL collision_pulse dut %0d: got %b, required 1", d, col[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (col[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL collision_one_cycle dut %0d: got %b, required 0", d, col[d]);
            end
        end
        drive(1, 0, 4'h0, 4'd9, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0);
        @(negedge clk);
        vectors++;
        if (rd[0] !== 32'h00221111) begin
            miscompares++;
            $display("FAIL collision_merge: got %h, required 00221111", rd[0]);
        end
        drive(1, 1, 4'h3, 4'd10, 32'h11111111, 1, 1, 4'hC, 4'd10, 32'h22222222);
        @(negedge clk);
        vectors++;
        if (col[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_disjoint: got %b, required 0", col[0]);
        end
        drive(0, 0, 4'h0, 4'd0, 32'h0, 1, 0, 4'h0, 4'd10, 32'h0);
        @(negedge clk);
        vectors++;
        if (rd[1] !== 32'h22221111) begin
            miscompares++;
            $display("FAIL collision_disjoint_data: got %h, required 22221111", rd[1]);
        end
        // overlapping lanes at different addresses are not a collision
        drive(1, 1, 4'hF, 4'd11, 32'h33333333, 1, 1, 4'hF, 4'd12, 32'h44444444);
        @(negedge clk);
        vectors++;
        if (col[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_diff_addr: got %b, required 0", col[0]);
        end
        // A reads while B writes the same word: A sees the old word
        drive(1, 0, 4'h0, 4'd9, 32'h0, 1, 1, 4'hF, 4'd9, 32'hFFFFFFFF);
        @(negedge clk);
        vectors++;
        if (rd[0] !== 32'h00221111) begin
            miscompares++;
            $display("FAIL cross_read_old: got %h, required 00221111", rd[0]);
        end
        idle(3);
    endtask

    task automatic test_out_reg();
        drive(1, 1, 4'hF, 4'd1, 32'h01010101, 1, 1, 4'hF, 4'd2, 32'h02020202);
        drive(1, 1, 4'hF, 4'd3, 32'h03030303, 0, 0, 4'h0, 4'd0, 32'h0);
        idle(3);
        fork
            begin
                drive(0, 0, 4'h0, 4'd0, 32'h0, 1, 0, 4'h0, 4'd1, 32'h0);
                drive(0, 0, 4'h0, 4'd0, 32'h0, 1, 0, 4'h0, 4'd2, 32'h0);
                drive(0, 0, 4'h0, 4'd0, 32'h0, 1, 0, 4'h0, 4'd3, 32'h0);
            end
            begin
                logic exp_v [6];
                exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    vectors++;
                    if (rv[5] !== exp_v[i]) begin
                        miscompares++;
                        $display("FAIL out_reg_rvalid negedge %0d: got %b, required %b", i, rv[5], exp_v[i]);
                    end
                end
            end
        join
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), $urandom);
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 4'hF, 4'd5, 32'hCAFEF00D, 1, 1, 4'hF, 4'd12, 32'h0BADBEEF);
        idle(4);
        @(negedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        mdl_ready = 0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        a_en = 1; a_we = 1; a_be = 4'hF; a_addr = 4'd12; a_wdata = 32'hDEADBEEF;
        b_en = 1; b_we = 0; b_be = 4'h0; b_addr = 4'd5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (bsy[0] !== 1'b1 || rv[0] !== 1'b0 || rv[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_clear_busy cycle %0d: got busy %b rvA %b rvB %b, required 1 0 0", i, bsy[0], rv[0], rv[1]);
            end
        end
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                vectors++;
                if (bsy[d] !== 1'b1 || rv[2*d] !== 1'b0 || rv[2*d+1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL restart_busy dut %0d cycle %0d: got busy %b rvA %b rvB %b, required 1 0 0",
                             d, i, bsy[d], rv[2*d], rv[2*d+1]);
                end
            end
        end
        #1 idle_inputs();
        @(negedge clk);
        vectors++;
        if (bsy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_done: got busy %b, required 0", bsy[0]);
        end
        mdl_ready = 1;
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 4'h0, 4'(i), 32'h0, 1, 0, 4'h0, 4'(15 - i), 32'h0);
        end
        idle(4);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mdl_ready   = 0;
        rst         = 1;
        idle_inputs();
        test_reset();
        test_clear_readback();
        test_byte_enable();
        test_rdw();
        test_collision();
        test_out_reg();
        test_back_to_back();
        test_reset_mid();
        for (int p = 0; p < 6; p++) begin
            vectors++;
            if (sb[p].size() != 0) begin
                miscompares++;
                $display("FAIL missing_rvalid port %0d: got %0d responses outstanding, required 0", p, sb[p].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dpram_be.md
Name: dpram_be

Overview:
- Parametrised true dual-port synchronous RAM; next generation of the byte-wide data-memory RAM.
- Adds configurable word width, per-byte write enables and selectable read-during-write mode.
- Adds an optional output pipeline register, deterministic cross-port write-collision resolution and a reset-time memory clear sequencer.
- Sits behind the LSU as data memory; port A serves the pipeline MEM stage, port B serves a debug/DMA master.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8
ADDR_W, 13, word address width; DEPTH = 2**ADDR_W words
RDW_MODE, 0, same-port read-during-write: 0 = write-first (new data), 1 = read-first (old data)
OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
CLEAR_ON_RST, 1, 1 zero-fills the whole array after reset; 0 leaves contents untouched

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
a_en  in  1  port A access request
a_we  in  1  port A write (valid when a_en=1)
a_be  in  DATA_W/8  port A byte-lane write enables
a_addr  in  ADDR_W  port A word address
a_wdata  in  DATA_W  port A write data
a_rdata  out  DATA_W  port A read data
a_rvalid  out  1  port A read data valid (one-cycle pulse per access)
b_en, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid  as port A, for port B
busy  out  1  clear sequence in progress; all requests ignored
collision  out  1  one-cycle pulse: both ports wrote the same address with overlapping byte lanes

Behaviour:
- Reset values: a_rdata=b_rdata=0, a_rvalid=b_rvalid=0, collision=0, busy=CLEAR_ON_RST, clear counter=0.
- FSM (CLEAR_ON_RST=1):
  - CLEAR: writes all-zero word at counter address, counter+1 per cycle, busy=1.
  - On counter=DEPTH-1, write it and go to READY the next cycle (busy=0 after exactly DEPTH cycles).
  - READY: normal operation.
  - rst asserted in any state returns to CLEAR with counter=0.
- CLEAR_ON_RST=0: FSM held in READY, busy=0.
- While busy=1: a_en/b_en ignored, no writes from ports, rvalid stays 0.
- Access accepted when x_en=1 and busy=0.
  - Write: lanes with x_be[i]=1 update bits [8i+7:8i]; other lanes unchanged.
  - Every accepted access (read or write) returns data and pulses x_rvalid.
- Latency: x_rdata/x_rvalid appear 1 cycle after acceptance (OUT_REG=0) or 2 cycles (OUT_REG=1); fully pipelined, one access per port per cycle.
- Same-port write returned data:
  - RDW_MODE=0: merged post-write word.
  - RDW_MODE=1: pre-write word.
- Cross-port, same address, same cycle:
  - Both writing: per byte lane, port A wins where both enables set; non-overlapping lanes from each port both land.
  - collision pulses 1 cycle after the event iff any lane overlaps.
  - Each port's returned data follows its own RDW_MODE rule, computed from its own write only.
  - One reads, other writes: reader returns old (pre-write) word.
- x_rdata holds its last value when no access completes; x_rvalid=0 then.
- Address wrap: none; ADDR_W bits cover the full array.

Test Plan:
- Reset clear: rst 1 cycle, DATA_W=32, ADDR_W=4 -> busy=1 for exactly 16 cycles; then read addr 0..15 -> all 0x00000000, rvalid 1 cycle after each request.
- Byte enables: write 0xAABBCCDD addr 3 be=1111, then write 0x11223344 be=0101 -> read addr 3 returns 0xAA22CC44.
- RDW mode: RDW_MODE=0, word holds 0x12345678, write 0xFFFFFFFF be=1111 -> rdata 0xFFFFFFFF; RDW_MODE=1 same stimulus -> rdata 0x12345678.
- Collision: A writes 0x11111111 be=0011, B writes 0x22222222 be=0110, same addr, same cycle -> stored 0x00221111 (from zero), collision=1 for one cycle; disjoint be=0011/1100 -> 0x22221111, collision=0.
- OUT_REG=1: back-to-back reads addr 1,2,3 on port B -> rdata in cycles +2,+3,+4 with rvalid continuous.
- Reset mid-clear: assert rst at clear cycle 7 -> counter restarts; busy stays 1 for 16 further cycles; requests during busy -> no write, rvalid=0.
